// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int                  STAT_WIDTH = 16;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first valid index at or after start, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      int j;
      j = (int'(start) + off) % N;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j[IW-1:0];
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-locking arbiter sharing the FIFO write port, with a one-entry output stage.
// Optional per-requester accepted-beat counters under `FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk_in,
  input  logic                          areset_b,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          wr_trans_enable,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [ID_WIDTH-1:0]           wr_src_id,
  input  logic                          stat_clr,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_cnt
);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   acc_idx;
  logic                  stage_free;
  logic                  accept;
  logic                  consume;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .valid (req_valid),
    .start (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // State register
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output decode: who may hand over a beat this cycle
  always_comb begin
    grant      = '0;
    acc_idx    = pick_idx;
    stage_free = ~out_valid_q | ~fifo_full;
    if (state_q == ARB_LOCKED) begin
      // Owner keeps the port even while it idles mid-burst.
      grant[owner_q] = 1'b1;
      acc_idx        = owner_q;
    end else if (pick_any) begin
      grant = pick_grant;
    end
    req_ready = stage_free ? grant : '0;
    accept    = |(req_valid & req_ready);
    consume   = out_valid_q & ~fifo_full;
  end

  // Next-state
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (req_last[acc_idx]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (acc_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : acc_idx + 1'b1;
      end else begin
        state_d = ARB_LOCKED;
        owner_d = acc_idx;
      end
    end
  end

  // Output stage: reload on accept (covers same-cycle consume), else drain on consume.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];
      out_id_d    = acc_idx;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign wr_trans_enable = out_valid_q;
  assign wr_data         = out_data_q;
  assign wr_src_id       = out_id_q;

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (stat_clr)
        cnt_d = '0;
      else if (req_valid[g] && req_ready[g] && cnt_q != STAT_MAX)
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
      if (!areset_b) cnt_q <= '0;
      else           cnt_q <= cnt_d;
    end

    assign stat_cnt[g*STAT_WIDTH +: STAT_WIDTH] = cnt_q;
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: vector table plus hand sequences for full, reset and stats.
module tb_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic             clk_in = 1'b0;
  logic             areset_b;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             fifo_full, wr_trans_enable, stat_clr;
  logic [DW-1:0]    wr_data;
  logic [IW-1:0]    wr_src_id;
  logic [NR*16-1:0] stat_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n5a     = 0;

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_in          (clk_in),
    .areset_b        (areset_b),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .wr_trans_enable (wr_trans_enable),
    .wr_data         (wr_data),
    .wr_src_id       (wr_src_id),
    .stat_clr        (stat_clr),
    .stat_cnt        (stat_cnt)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in)
    if (areset_b && wr_trans_enable && !fifo_full && wr_data == 8'h5A) n5a++;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic        en;
    logic [7:0]  wd;
    logic [1:0]  id;
  } vec_t;

  vec_t tv[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic f);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fifo_full = f;
  endtask

  initial begin
    // Single-beat round robin, then a 3-beat locked burst from req1.
    tv[0]  = '{4'hF, 4'hF, 32'h13121110, 4'b0001, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{4'hF, 4'hF, 32'h13121110, 4'b0010, 1'b1, 8'h10, 2'd0};
    tv[2]  = '{4'hF, 4'hF, 32'h13121110, 4'b0100, 1'b1, 8'h11, 2'd1};
    tv[3]  = '{4'hF, 4'hF, 32'h13121110, 4'b1000, 1'b1, 8'h12, 2'd2};
    tv[4]  = '{4'hF, 4'hF, 32'h13121110, 4'b0001, 1'b1, 8'h13, 2'd3};
    tv[5]  = '{4'h0, 4'hF, 32'h13121110, 4'b0000, 1'b1, 8'h10, 2'd0};
    tv[6]  = '{4'h0, 4'hF, 32'h13121110, 4'b0000, 1'b0, 8'h10, 2'd0};
    tv[7]  = '{4'h7, 4'hD, 32'h00C0A1B0, 4'b0010, 1'b0, 8'h10, 2'd0};
    tv[8]  = '{4'h7, 4'hD, 32'h00C0A2B0, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tv[9]  = '{4'h7, 4'hF, 32'h00C0A3B0, 4'b0010, 1'b1, 8'hA2, 2'd1};
    tv[10] = '{4'h5, 4'hF, 32'h00C000B0, 4'b0100, 1'b1, 8'hA3, 2'd1};
    tv[11] = '{4'h1, 4'hF, 32'h00C000B0, 4'b0001, 1'b1, 8'hC0, 2'd2};
    tv[12] = '{4'h0, 4'hF, 32'h00C000B0, 4'b0000, 1'b1, 8'hB0, 2'd0};
    tv[13] = '{4'h0, 4'hF, 32'h00C000B0, 4'b0000, 1'b0, 8'hB0, 2'd0};

    areset_b = 1'b0;
    stat_clr = 1'b0;
    drive(4'h0, 4'h0, 32'h0, 1'b0);
    #1;
    chk("rst en",    wr_trans_enable, 1'b0);
    chk("rst data",  wr_data, 8'h00);
    chk("rst id",    wr_src_id, 2'd0);
    chk("rst ready", req_ready, 4'h0);
    chk("rst stat",  stat_cnt, 64'h0);
    repeat (2) @(negedge clk_in);
    areset_b = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk_in);
      drive(tv[i].valid, tv[i].last, tv[i].data, 1'b0);
      #1;
      chk($sformatf("v%0d ready", i), req_ready, tv[i].rdy);
      chk($sformatf("v%0d en", i),    wr_trans_enable, tv[i].en);
      chk($sformatf("v%0d data", i),  wr_data, tv[i].wd);
      chk($sformatf("v%0d id", i),    wr_src_id, tv[i].id);
    end

    // Full stall: 0x5A from req1 held five cycles, written exactly once.
    @(negedge clk_in);
    drive(4'b0010, 4'hF, 32'h00005A00, 1'b0);
    #1 chk("full accept ready", req_ready, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      drive(4'hF, 4'hF, 32'h77777777, 1'b1);
      #1;
      chk($sformatf("full%0d en", c),    wr_trans_enable, 1'b1);
      chk($sformatf("full%0d data", c),  wr_data, 8'h5A);
      chk($sformatf("full%0d id", c),    wr_src_id, 2'd1);
      chk($sformatf("full%0d ready", c), req_ready, 4'h0);
    end
    @(negedge clk_in);
    drive(4'h0, 4'hF, 32'h0, 1'b0);
    #1 chk("unfull en", wr_trans_enable, 1'b1);
    chk("unfull data", wr_data, 8'h5A);
    @(negedge clk_in);
    #1 chk("drained en", wr_trans_enable, 1'b0);
    chk("5A writes", n5a, 1);

    // Reset in the middle of a req3 burst (rr_ptr is 2 here).
    @(negedge clk_in);
    drive(4'b1000, 4'h0, 32'hD1000000, 1'b0);
    #1 chk("r3 ready", req_ready, 4'b1000);
    @(negedge clk_in);
    drive(4'b1001, 4'h0, 32'hD20000B0, 1'b0);
    #1 chk("r3 locked ready", req_ready, 4'b1000);
    chk("r3 beat1", wr_data, 8'hD1);
    chk("r3 id", wr_src_id, 2'd3);
    @(negedge clk_in);
    drive(4'b0001, 4'h0, 32'hD20000B0, 1'b0);
    #1 chk("owner idle ready", req_ready, 4'b1000);
    chk("r3 beat2", wr_data, 8'hD2);
    @(negedge clk_in);
    drive(4'b1001, 4'h0, 32'hD30000B0, 1'b0);
    areset_b = 1'b0;
    #1 chk("mid rst en", wr_trans_enable, 1'b0);
    chk("mid rst data", wr_data, 8'h00);
    chk("mid rst id", wr_src_id, 2'd0);
    chk("mid rst ready", req_ready, 4'b0001);
    @(negedge clk_in);
    areset_b = 1'b1;
    #1 chk("post rst ready", req_ready, 4'b0001);
    @(negedge clk_in);
    drive(4'h0, 4'hF, 32'h0, 1'b0);
    #1 chk("post rst en", wr_trans_enable, 1'b1);
    chk("post rst id", wr_src_id, 2'd0);
    chk("post rst data", wr_data, 8'hB0);

`ifdef FIFO_WR_ARB_STATS_EN
    @(negedge clk_in);
    areset_b = 1'b0;
    @(negedge clk_in);
    areset_b = 1'b1;
    #1 chk("stat after rst", stat_cnt, 64'h0);
    drive(4'b0100, 4'hF, 32'h00220000, 1'b0);
    repeat (70000) @(negedge clk_in);
    #1 chk("stat sat", stat_cnt[47:32], 16'hFFFF);
    chk("stat others", {stat_cnt[63:48], stat_cnt[31:0]}, 48'h0);
    stat_clr = 1'b1;
    @(negedge clk_in);
    stat_clr = 1'b0;
    drive(4'h0, 4'hF, 32'h0, 1'b0);
    #1 chk("stat clr", stat_cnt, 64'h0);
`else
    chk("stat off", stat_cnt, 64'h0);
    stat_clr = 1'b1;
    @(negedge clk_in);
    stat_clr = 1'b0;
    #1 chk("stat off clr", stat_cnt, 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Write-side arbiter for the FIFO memory: shares the single FIFO write port among `NUM_REQ` requesters using round-robin with burst locking. It drives `trans_enable` and write data into the write-pointer/memory path and honours the FIFO full indication so no beat is ever dropped. A one-entry registered output stage decouples requester timing from the FIFO write path.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_WIDTH`, 8: beat width
- `ID_WIDTH`, 2: width of source id, $clog2(NUM_REQ)
- `clk_in`  in  1  clock, all logic rising-edge
- `areset_b`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester beat valid
- `req_last`  in  NUM_REQ  beat ends requester's burst
- `req_data`  in  NUM_REQ*DATA_WIDTH  flat beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  beat accepted when valid&ready
- `fifo_full`  in  1  FIFO full flag
- `wr_trans_enable`  out  1  write request to pointer/memory path
- `wr_data`  out  DATA_WIDTH  write beat
- `wr_src_id`  out  ID_WIDTH  requester index of current beat
- `stat_clr`  in  1  clear statistics counters (see Configuration)
- `stat_cnt`  out  NUM_REQ*16  per-requester accepted-beat counters

## Operation
- States: IDLE (no owner), LOCKED (owner mid-burst). Registers: `state`, `owner`, `rr_ptr`, output stage (`out_valid`, data, id).
- IDLE: grant = first `req_valid` index at or after `rr_ptr`, wrapping modulo NUM_REQ; none valid -> no grant.
- LOCKED: only `owner` granted; other requesters see `req_ready`=0 even if owner deasserts valid.
- Output stage free = `~out_valid | ~fifo_full`. `req_ready[i]` = granted(i) & stage free; at most one bit set.
- Accepted beat with `req_last`=0 -> LOCKED, `owner`=i. With `req_last`=1 -> IDLE, `rr_ptr`=(i+1) mod NUM_REQ, wrap from NUM_REQ-1 to 0.
- `wr_trans_enable` = `out_valid`. Beat consumed when `out_valid & ~fifo_full`; matches pointer block's advance rule (`~full & trans_enable`). While full, stage holds data/id stable.
- Simultaneous consume and accept: stage reloads same cycle, back-to-back beats at full throughput.
- Reset (any time, incl. mid-burst): IDLE, `rr_ptr`=0, `owner`=0, `out_valid`=0; partial burst abandoned, no beat emitted.

## Timing
- Reset values: `wr_trans_enable`=0, `wr_data`=0, `wr_src_id`=0, `req_ready`=0 only when no valid request, `stat_cnt`=0.
- `req_ready` is combinational from state, `req_valid`, `out_valid`, `fifo_full`; no comb path from `req_data`.
- Latency: beat accepted at edge N appears on `wr_*` after edge N, held until consumed.
- Throughput: 1 beat/cycle while `fifo_full`=0.
- `fifo_full` rise: current stage beat held; no new accept until full falls.

## Configuration
- Macro `FIFO_WR_ARB_STATS_EN`.
- Defined: per-requester 16-bit counters increment on each accepted beat, saturate at 16'hFFFF; `stat_clr` synchronously zeroes all counters and wins over same-cycle increment; reset zeroes.
- Undefined: counters not built, `stat_cnt` tied to 0, `stat_clr` ignored. Ports present in both builds.

## Structure
- Package `fifo_arb_pkg`: `arb_state_e` enum {ARB_IDLE, ARB_LOCKED}, `STAT_WIDTH`=16, `STAT_MAX`.
- Sub-module `rr_pick`: combinational round-robin picker (valid vector, start pointer -> one-hot grant + index); instantiated once.

## Test plan
- All 4 requesters valid, single-beat bursts (`req_last`=1), `fifo_full`=0 -> `wr_src_id` sequence 0,1,2,3,0 one beat per cycle.
- Req1 burst of 3 beats (A1,A2,A3), req0/req2 valid throughout -> A1,A2,A3 contiguous on `wr_data`, then req2 granted, then req0.
- `fifo_full`=1 for 5 cycles with beat 0x5A in stage -> `wr_trans_enable`=1, `wr_data`=0x5A stable, all `req_ready`=0; after full falls exactly one 0x5A write.
- `areset_b` asserted mid-burst of req3 -> outputs 0, IDLE; after release, req0 granted first with req0 and req3 valid.
- With `FIFO_WR_ARB_STATS_EN`: 70000 beats from req2 -> `stat_cnt[2]`=16'hFFFF; `stat_clr` pulse -> 0; without macro -> always 0.
